// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU VRAM write port: region map,
// per-region local address widths and the write-window FSM states.
package ppu_pkg;

    localparam logic [12:0] TILE_BASE    = 13'h0000;
    localparam logic [12:0] PATTERN_BASE = 13'h0800;
    localparam logic [12:0] PALETTE_BASE = 13'h1800;
    localparam logic [12:0] SPRITE_BASE  = 13'h1A00;
    localparam logic [12:0] SPRITE_LAST  = 13'h1A27;

    localparam int TILE_AW    = 11;
    localparam int PATTERN_AW = 12;
    localparam int PALETTE_AW = 9;
    localparam int SPRITE_AW  = 6;
    localparam int LOCAL_AW   = 12;

    // Bit positions inside the decoder's region one-hot
    localparam int RGN_TILE    = 0;
    localparam int RGN_PATTERN = 1;
    localparam int RGN_PALETTE = 2;
    localparam int RGN_SPRITE  = 3;

    typedef enum logic [1:0] {
        S_RENDER,
        S_IRQ,
        S_WAIT_BUSY,
        S_WINDOW
    } vram_wr_state_t;

endpackage

// File: rtl/vram_addr_decode.sv
// Combinational map from a 13-bit VRAM word address to a region one-hot,
// the address local to that region, and an out-of-range indication.
module vram_addr_decode
    import ppu_pkg::*;
(
    input  logic [12:0]         addr,
    output logic [3:0]          region,
    output logic [LOCAL_AW-1:0] local_addr,
    output logic                oob
);

    // Regions are contiguous, so ascending compares pick exactly one
    always_comb begin
        region     = '0;
        local_addr = '0;
        oob        = 1'b0;
        if (addr < PATTERN_BASE) begin
            region[RGN_TILE] = 1'b1;
            local_addr       = LOCAL_AW'(addr - TILE_BASE);
        end else if (addr < PALETTE_BASE) begin
            region[RGN_PATTERN] = 1'b1;
            local_addr          = LOCAL_AW'(addr - PATTERN_BASE);
        end else if (addr < SPRITE_BASE) begin
            region[RGN_PALETTE] = 1'b1;
            local_addr          = LOCAL_AW'(addr - PALETTE_BASE);
        end else if (addr <= SPRITE_LAST) begin
            region[RGN_SPRITE] = 1'b1;
            local_addr         = LOCAL_AW'(addr - SPRITE_BASE);
        end else begin
            oob = 1'b1;
        end
    end

endmodule

// File: rtl/ppu_vram_write_port.sv
// PPU-side responder for HPS VRAM writes: opens a write window each vblank,
// routes accepted writes to the tile/pattern/palette/sprite RAM ports.
module ppu_vram_write_port
    import ppu_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 64,
    parameter int DROP_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vblank_start,
    input  logic                  vblank_end_soon,
    output logic                  cpu_vram_wr_irq,
    input  logic                  cpu_wr_busy,
    input  logic [12:0]           h2f_vram_wraddr,
    input  logic                  h2f_vram_wren,
    input  logic [63:0]           h2f_vram_wrdata,
    input  logic [7:0]            h2f_vram_byteena,
    output logic                  tile_wren,
    output logic [TILE_AW-1:0]    tile_wraddr,
    output logic                  pattern_wren,
    output logic [PATTERN_AW-1:0] pattern_wraddr,
    output logic                  palette_wren,
    output logic [PALETTE_AW-1:0] palette_wraddr,
    output logic                  sprite_wren,
    output logic [SPRITE_AW-1:0]  sprite_wraddr,
    output logic [63:0]           ram_wrdata,
    output logic [7:0]            ram_byteena,
    output logic                  window_open,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  oob_err,
    output logic                  forced_close,
    input  logic                  status_clr
);

    localparam int TIMER_W = ($clog2(BUSY_TIMEOUT) > 0) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

    vram_wr_state_t      state;
    logic [TIMER_W-1:0]  timer;

    logic [3:0]          dec_region;
    logic [LOCAL_AW-1:0] dec_local;
    logic                dec_oob;

    logic accept;
    logic drop;
    logic wr_ok;
    logic force_evt;

    vram_addr_decode u_decode (
        .addr       (h2f_vram_wraddr),
        .region     (dec_region),
        .local_addr (dec_local),
        .oob        (dec_oob)
    );

    // The window flag is the registered view of the state, so a write that
    // lands on the closing cycle still sees window_open high and is kept.
    assign accept = h2f_vram_wren && window_open;
    assign drop   = h2f_vram_wren && !window_open;
    assign wr_ok  = accept && !dec_oob;

    // Busy rising takes priority in WAIT_BUSY; busy falling wins in WINDOW
    assign force_evt = vblank_end_soon &&
                       (((state == S_WAIT_BUSY) && !cpu_wr_busy) ||
                        ((state == S_WINDOW)    &&  cpu_wr_busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_RENDER;
            timer           <= '0;
            cpu_vram_wr_irq <= 1'b0;
            window_open     <= 1'b0;
        end else begin
            cpu_vram_wr_irq <= 1'b0;
            case (state)
                S_RENDER: begin
                    if (vblank_start) begin
                        state           <= S_IRQ;
                        cpu_vram_wr_irq <= 1'b1;
                        window_open     <= 1'b1;
                    end
                end
                S_IRQ: begin
                    state <= S_WAIT_BUSY;
                    timer <= '0;
                end
                S_WAIT_BUSY: begin
                    if (cpu_wr_busy) begin
                        state <= S_WINDOW;
                    end else if (vblank_end_soon || (timer == TIMER_LAST)) begin
                        state       <= S_RENDER;
                        window_open <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WINDOW: begin
                    if (!cpu_wr_busy || vblank_end_soon) begin
                        state       <= S_RENDER;
                        window_open <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_RENDER;
                    window_open <= 1'b0;
                end
            endcase
        end
    end

    // Write strobes pulse for one cycle; addresses and data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_wren      <= 1'b0;
            pattern_wren   <= 1'b0;
            palette_wren   <= 1'b0;
            sprite_wren    <= 1'b0;
            tile_wraddr    <= '0;
            pattern_wraddr <= '0;
            palette_wraddr <= '0;
            sprite_wraddr  <= '0;
            ram_wrdata     <= '0;
            ram_byteena    <= '0;
        end else begin
            tile_wren    <= wr_ok && dec_region[RGN_TILE];
            pattern_wren <= wr_ok && dec_region[RGN_PATTERN];
            palette_wren <= wr_ok && dec_region[RGN_PALETTE];
            sprite_wren  <= wr_ok && dec_region[RGN_SPRITE];
            if (wr_ok && dec_region[RGN_TILE])
                tile_wraddr <= dec_local[TILE_AW-1:0];
            if (wr_ok && dec_region[RGN_PATTERN])
                pattern_wraddr <= dec_local[PATTERN_AW-1:0];
            if (wr_ok && dec_region[RGN_PALETTE])
                palette_wraddr <= dec_local[PALETTE_AW-1:0];
            if (wr_ok && dec_region[RGN_SPRITE])
                sprite_wraddr <= dec_local[SPRITE_AW-1:0];
            if (wr_ok) begin
                ram_wrdata  <= h2f_vram_wrdata;
                ram_byteena <= h2f_vram_byteena;
            end
        end
    end

    // Status: a set event in the same cycle as status_clr wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count   <= '0;
            oob_err      <= 1'b0;
            forced_close <= 1'b0;
        end else begin
            if (drop) begin
                if (status_clr)
                    drop_count <= DROP_CNT_W'(1);
                else if (drop_count != '1)
                    drop_count <= drop_count + 1'b1;
            end else if (status_clr) begin
                drop_count <= '0;
            end

            if (accept && dec_oob)
                oob_err <= 1'b1;
            else if (status_clr)
                oob_err <= 1'b0;

            if (force_evt)
                forced_close <= 1'b1;
            else if (status_clr)
                forced_close <= 1'b0;
        end
    end

endmodule

// File: doc/ppu_vram_write_port.md
Name: ppu_vram_write_port

Overview:
- PPU-side responder to the HPS-to-FPGA VRAM write interface, clocked in the clk (50 MHz) domain.
- Opens a CPU write window each vblank, raises cpu_vram_wr_irq and tracks the CPU's cpu_wr_busy handshake.
- Decodes each 13-bit word address into the tile, pattern, palette or sprite RAM write port.
- Drops and counts writes outside the window; flags out-of-range addresses.

Parameters:
BUSY_TIMEOUT, 64, clk cycles allowed after the IRQ for cpu_wr_busy to rise before the window is abandoned
DROP_CNT_W, 8, width of the saturating dropped-write counter

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
vblank_start  in  1  single-cycle pulse, already synchronized to clk
vblank_end_soon  in  1  single-cycle pulse, already synchronized to clk; forces window closed
cpu_vram_wr_irq  out  1  single-cycle write-window request to the CPU
cpu_wr_busy  in  1  CPU holds high while its write burst is in progress
h2f_vram_wraddr  in  13  VRAM word address
h2f_vram_wren  in  1  write strobe
h2f_vram_wrdata  in  64  write data
h2f_vram_byteena  in  8  byte enables
tile_wren  out  1  tile RAM write enable
tile_wraddr  out  11  tile RAM local address
pattern_wren  out  1  pattern RAM write enable
pattern_wraddr  out  12  pattern RAM local address
palette_wren  out  1  palette RAM write enable
palette_wraddr  out  9  palette RAM local address
sprite_wren  out  1  sprite RAM write enable
sprite_wraddr  out  6  sprite RAM local address
ram_wrdata  out  64  registered write data, shared by all regions
ram_byteena  out  8  registered byte enables, shared by all regions
window_open  out  1  high while writes are accepted
drop_count  out  DROP_CNT_W  saturating count of writes dropped outside the window
oob_err  out  1  sticky flag: write address above 0x1A27
forced_close  out  1  sticky flag: window ended by vblank_end_soon while still open
status_clr  in  1  clears drop_count, oob_err and forced_close

Behaviour:
- Reset: every output is 0, FSM is in S_RENDER, timer is 0.
- FSM states are S_RENDER, S_IRQ, S_WAIT_BUSY and S_WINDOW.
- S_RENDER:
  - vblank_start goes to S_IRQ.
  - Otherwise stays in S_RENDER.
- S_IRQ:
  - cpu_vram_wr_irq is 1 for exactly this one cycle (registered Moore output).
  - Next state is always S_WAIT_BUSY; timer is cleared.
- S_WAIT_BUSY:
  - cpu_wr_busy=1 goes to S_WINDOW.
  - vblank_end_soon goes to S_RENDER and sets forced_close.
  - timer==BUSY_TIMEOUT-1 goes to S_RENDER with no flag.
  - Otherwise timer increments.
- S_WINDOW:
  - cpu_wr_busy=0 goes to S_RENDER (normal close).
  - vblank_end_soon goes to S_RENDER and sets forced_close.
  - If both occur in the same cycle, it is a normal close and forced_close is not set.
- vblank_start outside S_RENDER is ignored.
- window_open = 1 in S_IRQ, S_WAIT_BUSY and S_WINDOW.
- Write acceptance:
  - A write sampled with h2f_vram_wren=1 is accepted when window_open=1 in that cycle.
  - This holds even if the same cycle causes the window to close, so the final write coincident with busy falling or vblank_end_soon is kept.
- Decode of an accepted write (1-cycle latency; outputs registered; at most one *_wren high per cycle):
  - 0x0000–0x07FF goes to tile, local address addr[10:0].
  - 0x0800–0x17FF goes to pattern, local address addr-0x0800.
  - 0x1800–0x19FF goes to palette, local address addr-0x1800.
  - 0x1A00–0x1A27 goes to sprite, local address addr-0x1A00.
  - Above 0x1A27: no *_wren; oob_err is set.
- ram_wrdata and ram_byteena load only on an accepted in-range write; they hold otherwise.
- Any *_wren deasserts in the following cycle unless another accepted write arrives. Back-to-back writes every cycle are supported.
- Dropped write: h2f_vram_wren=1 while window_open=0. No *_wren is asserted; drop_count increments and saturates at all-ones.
- An out-of-range write outside the window counts as dropped only; oob_err is not set.
- status_clr:
  - Synchronous; clears drop_count, oob_err and forced_close.
  - If a set event occurs in the same cycle, the set wins and the count becomes 1.
- Reset asserted mid-window:
  - All outputs clear immediately and the FSM returns to S_RENDER.
  - Any write in flight is lost.

Decomposition:
- Package ppu_pkg holds:
  - region base/limit constants: TILE_BASE=13'h0000, PATTERN_BASE=13'h0800, PALETTE_BASE=13'h1800, SPRITE_BASE=13'h1A00, SPRITE_LAST=13'h1A27;
  - local address widths 11/12/9/6;
  - enum typedef vram_wr_state_t for the four FSM states.
- One sub-module, vram_addr_decode: combinational mapping from the 13-bit address to a region one-hot, the local address and an out-of-range bit. The registering stays in the parent.

Test Plan:
1. Reset, then vblank_start pulse → cpu_vram_wr_irq high exactly 1 cycle later for 1 cycle; window_open=1; busy rises next cycle → S_WINDOW.
2. In the window, eight consecutive writes to 0x0000, 0x07FF, 0x0800, 0x17FF, 0x1800, 0x19FF, 0x1A00, 0x1A27, data 64'd12345, byteena 8'hFF, with busy falling in the cycle after the last write → one cycle after each write, the expected one-hot *_wren with local addresses 0, 0x7FF, 0, 0xFFF, 0, 0x1FF, 0, 0x27; all 8 accepted; window_open=0 afterwards; drop_count=0.
3. Write to 0x0123 during S_RENDER → no *_wren; drop_count=1. Repeat 300 times → drop_count=255. status_clr → 0.
4. In the window, write to 0x1A28 → no *_wren; oob_err=1 and stays 1 until status_clr.
5. IRQ issued, busy held 0 → after 64 cycles the FSM returns to S_RENDER; forced_close=0. Separately: busy held 1 and vblank_end_soon pulsed with a write to 0x0010 in the same cycle → tile_wren next cycle; window closes; forced_close=1.
6. rst_n pulsed low while in S_WINDOW with wren=1 → all outputs 0 immediately; next vblank_start restarts the IRQ sequence normally.
